// File: rtl/frame_scheduler.sv
// Ping-pong capture sequencer for the audio front end: paces sample writes into two
// banks and hands each full bank downstream over a level req / pulse ack handshake.
module frame_scheduler #(
    parameter int CLK_DIV    = 6250,
    parameter int FRAME_LEN  = 256,
    parameter int MAX_FRAMES = 64,
    localparam int AW = $clog2(FRAME_LEN),
    localparam int FW = $clog2(MAX_FRAMES),
    localparam int DW = $clog2(CLK_DIV),
    localparam int CW = FW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    output logic          sample_we_o,
    output logic          wr_bank_o,
    output logic [AW-1:0] wr_addr_o,
    output logic          frame_req_o,
    output logic          rd_bank_o,
    output logic [FW-1:0] frame_idx_o,
    input  logic          frame_ack_i,
    output logic          overrun_o,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_FRAMES - 1);

    state_t        state_q;
    logic [DW-1:0] div_q;
    logic [AW-1:0] wr_addr_q;
    logic          wr_bank_q;
    logic [CW-1:0] count_q;
    logic          frame_req_q;
    logic          rd_bank_q;
    logic [FW-1:0] frame_idx_q;
    logic          overrun_q;
    logic          done_q;

    logic strobe;
    assign strobe = (state_q == CAPTURE) && (div_q == DIV_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            div_q       <= '0;
            wr_addr_q   <= '0;
            wr_bank_q   <= 1'b0;
            count_q     <= '0;
            frame_req_q <= 1'b0;
            rd_bank_q   <= 1'b0;
            frame_idx_q <= '0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q     <= IDLE;
                frame_req_q <= 1'b0;
                div_q       <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            state_q     <= CAPTURE;
                            div_q       <= '0;
                            wr_addr_q   <= '0;
                            wr_bank_q   <= 1'b0;
                            overrun_q   <= 1'b0;
                            count_q     <= '0;
                            frame_idx_q <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (frame_req_q && frame_ack_i)
                            frame_req_q <= 1'b0;
                        if (strobe) begin
                            div_q     <= '0;
                            wr_addr_q <= wr_addr_q + AW'(1);
                            if (wr_addr_q == ADDR_LAST) begin
                                // An ack in this same cycle frees the slot for the new bank.
                                if (!frame_req_q || frame_ack_i) begin
                                    frame_req_q <= 1'b1;
                                    rd_bank_q   <= wr_bank_q;
                                    wr_bank_q   <= ~wr_bank_q;
                                    frame_idx_q <= count_q[FW-1:0];
                                    count_q     <= count_q + CW'(1);
                                    if (count_q == CNT_LAST)
                                        state_q <= DRAIN;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end
                        end else begin
                            div_q <= div_q + DW'(1);
                        end
                    end
                    DRAIN: begin
                        if (frame_req_q && frame_ack_i) begin
                            state_q     <= IDLE;
                            frame_req_q <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sample_we_o = strobe;
    assign wr_bank_o   = wr_bank_q;
    assign wr_addr_o   = wr_addr_q;
    assign frame_req_o = frame_req_q;
    assign rd_bank_o   = rd_bank_q;
    assign frame_idx_o = frame_idx_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with CLK_DIV=4, FRAME_LEN=8, MAX_FRAMES=3.
// k counts clock edges after the start edge; outputs are observed 1 ns after each edge.
module tb_frame_scheduler;

    localparam int CLK_DIV    = 4;
    localparam int FRAME_LEN  = 8;
    localparam int MAX_FRAMES = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       frame_ack = 1'b0;
    logic       sample_we;
    logic       wr_bank;
    logic [2:0] wr_addr;
    logic       frame_req;
    logic       rd_bank;
    logic [1:0] frame_idx;
    logic       overrun;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;
    int k = 0;

    frame_scheduler #(
        .CLK_DIV(CLK_DIV),
        .FRAME_LEN(FRAME_LEN),
        .MAX_FRAMES(MAX_FRAMES)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .abort_i(abort),
        .sample_we_o(sample_we),
        .wr_bank_o(wr_bank),
        .wr_addr_o(wr_addr),
        .frame_req_o(frame_req),
        .rd_bank_o(rd_bank),
        .frame_idx_o(frame_idx),
        .frame_ack_i(frame_ack),
        .overrun_o(overrun),
        .busy_o(busy),
        .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        frame_ack = 1'b0;
    endtask

    function automatic logic [11:0] all_out();
        return {sample_we, wr_bank, wr_addr, frame_req, rd_bank, frame_idx, overrun, busy, done};
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (all_out() !== 12'h000) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=000", i, all_out());
            end
            tick();
        end
    endtask

    task automatic test_capture();
        logic exp_we;
        int   fr;
        fr = 0;
        start_pulse();
        for (int kk = 1; kk <= 100; kk++) begin
            tick();
            k = kk;
            exp_we = ((kk % 4) == 3) && (kk < 96);
            checks++;
            if (sample_we !== exp_we) begin
                failures++;
                $display("FAIL capture_we k=%0d got=%0b exp=%0b", kk, sample_we, exp_we);
            end
            if (exp_we) begin
                checks++;
                if (wr_addr !== 3'(((kk + 1) / 4 - 1) % 8)) begin
                    failures++;
                    $display("FAIL capture_addr k=%0d got=%0d exp=%0d", kk, wr_addr, ((kk + 1) / 4 - 1) % 8);
                end
            end
            if (kk == 32 || kk == 64 || kk == 96) begin
                checks++;
                if ({frame_req, rd_bank, frame_idx} !== {1'b1, 1'(fr % 2), 2'(fr)}) begin
                    failures++;
                    $display("FAIL capture_frame k=%0d got req=%0b rb=%0b idx=%0d exp req=1 rb=%0d idx=%0d",
                             kk, frame_req, rd_bank, frame_idx, fr % 2, fr);
                end
                fr++;
            end
            if (kk == 35 || kk == 67) begin
                checks++;
                if (frame_req !== 1'b0) begin
                    failures++;
                    $display("FAIL capture_req_clear k=%0d got=%0b exp=0", kk, frame_req);
                end
            end
            if (kk == 98) begin
                checks++;
                if ({busy, done} !== 2'b10) begin
                    failures++;
                    $display("FAIL capture_drain k=%0d got busy=%0b done=%0b exp busy=1 done=0", kk, busy, done);
                end
            end
            if (kk == 99) begin
                checks++;
                if ({busy, done, frame_req} !== 3'b010) begin
                    failures++;
                    $display("FAIL capture_done k=%0d got busy=%0b done=%0b req=%0b exp 0/1/0", kk, busy, done, frame_req);
                end
            end
            if (kk == 100) begin
                checks++;
                if (done !== 1'b0) begin
                    failures++;
                    $display("FAIL capture_done_width k=%0d got=%0b exp=0", kk, done);
                end
            end
            frame_ack = (kk == 34 || kk == 66 || kk == 98);
        end
        frame_ack = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL capture_overrun got=%0b exp=0", overrun);
        end
    endtask

    task automatic test_overrun();
        start_pulse();
        for (int kk = 1; kk <= 96; kk++) begin
            tick();
            k = kk;
            if (kk == 64) begin
                checks++;
                if ({overrun, wr_bank, frame_idx, frame_req, rd_bank} !== {1'b1, 1'b1, 2'd0, 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL overrun_drop got ovr=%0b wb=%0b idx=%0d req=%0b rb=%0b exp 1/1/0/1/0",
                             overrun, wr_bank, frame_idx, frame_req, rd_bank);
                end
            end
            if (kk == 67) begin
                checks++;
                if (frame_req !== 1'b0) begin
                    failures++;
                    $display("FAIL overrun_ack got req=%0b exp=0", frame_req);
                end
            end
            if (kk == 96) begin
                checks++;
                if ({frame_req, frame_idx, rd_bank, wr_bank, overrun, busy} !== {1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1}) begin
                    failures++;
                    $display("FAIL overrun_next got req=%0b idx=%0d rb=%0b wb=%0b ovr=%0b busy=%0b exp 1/1/1/0/1/1",
                             frame_req, frame_idx, rd_bank, wr_bank, overrun, busy);
                end
            end
            frame_ack = (kk == 66);
        end
        do_abort();
        checks++;
        if ({busy, frame_req, done, overrun} !== 4'b0001) begin
            failures++;
            $display("FAIL overrun_abort got busy=%0b req=%0b done=%0b ovr=%0b exp 0/0/0/1", busy, frame_req, done, overrun);
        end
    endtask

    task automatic test_back_to_back();
        start_pulse();
        for (int kk = 1; kk <= 66; kk++) begin
            tick();
            k = kk;
            if (kk == 63) begin
                checks++;
                if ({sample_we, wr_addr, frame_req, rd_bank, frame_idx} !== {1'b1, 3'd7, 1'b1, 1'b0, 2'd0}) begin
                    failures++;
                    $display("FAIL b2b_before got we=%0b addr=%0d req=%0b rb=%0b idx=%0d exp 1/7/1/0/0",
                             sample_we, wr_addr, frame_req, rd_bank, frame_idx);
                end
            end
            if (kk == 64 || kk == 66) begin
                checks++;
                if ({frame_req, rd_bank, frame_idx, overrun} !== {1'b1, 1'b1, 2'd1, 1'b0}) begin
                    failures++;
                    $display("FAIL b2b_after k=%0d got req=%0b rb=%0b idx=%0d ovr=%0b exp 1/1/1/0",
                             kk, frame_req, rd_bank, frame_idx, overrun);
                end
            end
            frame_ack = (kk == 63);
        end
        do_abort();
    endtask

    task automatic test_abort();
        start_pulse();
        for (int kk = 1; kk <= 54; kk++) begin
            tick();
            k = kk;
            if (kk == 53) begin
                checks++;
                if ({wr_addr, wr_bank, frame_req, busy} !== {3'd5, 1'b1, 1'b1, 1'b1}) begin
                    failures++;
                    $display("FAIL abort_pre got addr=%0d wb=%0b req=%0b busy=%0b exp 5/1/1/1", wr_addr, wr_bank, frame_req, busy);
                end
            end
            if (kk == 54) begin
                checks++;
                if ({busy, frame_req, done} !== 3'b000) begin
                    failures++;
                    $display("FAIL abort_idle got busy=%0b req=%0b done=%0b exp 0/0/0", busy, frame_req, done);
                end
            end
            abort = (kk == 53);
        end
        abort = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({busy, done, sample_we} !== 3'b000) begin
                failures++;
                $display("FAIL abort_quiet cyc=%0d got busy=%0b done=%0b we=%0b exp 0/0/0", i, busy, done, sample_we);
            end
        end
        start_pulse();
        checks++;
        if ({busy, wr_bank, wr_addr, frame_req, overrun, frame_idx} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL abort_restart got busy=%0b wb=%0b addr=%0d req=%0b ovr=%0b idx=%0d exp 1/0/0/0/0/0",
                     busy, wr_bank, wr_addr, frame_req, overrun, frame_idx);
        end
        for (int kk = 1; kk <= 3; kk++) begin
            tick();
            k = kk;
        end
        checks++;
        if ({sample_we, wr_addr} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL abort_first_strobe got we=%0b addr=%0d exp 1/0", sample_we, wr_addr);
        end
        do_abort();
    endtask

    task automatic test_start_ignored_and_reset();
        start_pulse();
        for (int kk = 1; kk <= 97; kk++) begin
            tick();
            k = kk;
            if (kk == 14) begin
                checks++;
                if (sample_we !== 1'b0) begin
                    failures++;
                    $display("FAIL restart_ignored_14 got we=%0b exp=0", sample_we);
                end
            end
            if (kk == 15) begin
                checks++;
                if ({sample_we, wr_addr} !== {1'b1, 3'd3}) begin
                    failures++;
                    $display("FAIL restart_ignored_15 got we=%0b addr=%0d exp 1/3", sample_we, wr_addr);
                end
            end
            if (kk == 97) begin
                checks++;
                if ({busy, frame_req, frame_idx} !== {1'b1, 1'b1, 2'd2}) begin
                    failures++;
                    $display("FAIL drain_state got busy=%0b req=%0b idx=%0d exp 1/1/2", busy, frame_req, frame_idx);
                end
            end
            start = (kk == 10);
            frame_ack = (kk == 34 || kk == 66);
        end
        start = 1'b0;
        frame_ack = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (all_out() !== 12'h000) begin
            failures++;
            $display("FAIL async_reset got=%h exp=000", all_out());
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (all_out() !== 12'h000) begin
                failures++;
                $display("FAIL post_reset cyc=%0d got=%h exp=000", i, all_out());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_capture();
        test_overrun();
        test_back_to_back();
        test_abort();
        test_start_ignored_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
